// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with a byte-wide store.
// Each word access is split into four byte beats, and each byte access is one beat.
// mem_busy stalls the pipeline registers while a transfer is in flight.
//
// state | meaning
// IDLE  | waiting for mem_enable; captures the request and checks alignment
// XFER  | moves one byte per cycle at cap_addr + beat
// DONE  | one-cycle mem_done pulse, then back to IDLE
// ERR   | misaligned word: one-cycle mem_err + mem_done pulse, storage untouched
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              R,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

  state_t            state;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic              cap_rw;
  logic              cap_size;

  // Storage is deliberately not reset, so bytes written before a reset survive it.
  logic [7:0]        storage [DEPTH];

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;
  logic              last_beat;
  logic              wr_en;

  // Beat address, byte lanes and last-beat detection for the captured request.
  always_comb begin
    cur_addr  = cap_addr + ADDR_W'(beat);
    rd_byte   = storage[cur_addr];
    wr_byte   = cap_wdata[{beat, 3'b000} +: 8];
    last_beat = !cap_size || (beat == 2'd3);
    wr_en     = (state == XFER) && cap_rw;
  end

  // Stall in the request cycle itself so the pipeline never sees a bubble.
  assign mem_busy = (state == XFER) || ((state == IDLE) && mem_enable);

  // Byte write port. It is held off as soon as reset drops the FSM out of XFER.
  always_ff @(posedge clk) begin
    if (wr_en) storage[cur_addr] <= wr_byte;
  end

  // Request FSM with registered completion and error pulses.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      beat      <= 2'd0;
      cap_addr  <= '0;
      cap_wdata <= 32'h0;
      cap_rw    <= 1'b0;
      cap_size  <= 1'b0;
      mem_rdata <= 32'h0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_enable) begin
            cap_addr  <= mem_addr;
            cap_wdata <= mem_wdata;
            cap_rw    <= mem_rw;
            cap_size  <= mem_size;
            beat      <= 2'd0;
            if (mem_size && (mem_addr[1:0] != 2'b00)) begin
              state    <= ERR;
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (!cap_rw) begin
            // Beat 0 clears the upper bytes, which zero-extends byte loads.
            if (beat == 2'd0) mem_rdata <= {24'h0, rd_byte};
            else              mem_rdata[{beat, 3'b000} +: 8] <= rd_byte;
          end
          if (last_beat) begin
            state    <= DONE;
            mem_done <= 1'b1;
            beat     <= 2'd0;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. A scoreboard queue is filled when each request is issued.
// A negedge monitor pops an entry on every mem_done pulse and compares it.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        mem_enable = 1'b0;
  logic        mem_rw = 1'b0;
  logic        mem_size = 1'b0;
  logic [7:0]  mem_addr = 8'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_err;

  int total = 0;
  int bad = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rdata = 32'h0;
  logic [32:0] exp_q [$];

  data_mem_responder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .R(R), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (mem_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: rdata %h err %b with empty queue", mem_rdata, mem_err);
      end else begin
        e = exp_q.pop_front();
        check("sb_err", {31'h0, mem_err}, {31'h0, e[32]});
        check("sb_rdata", mem_rdata, e[31:0]);
      end
    end
  end

  // Issue one request, update the reference model, and check busy and latency.
  task automatic do_req(input bit rw, input bit size, input logic [7:0] addr,
                        input logic [31:0] wdata, input bit scramble);
    bit   mis;
    int   exp_lat;
    int   cycles;
    bit   got_done;
    logic [7:0] a;
    mis = size && (addr[1:0] != 2'b00);
    if (!mis) begin
      if (rw) begin
        if (size) begin
          for (int i = 0; i < 4; i++) begin
            a = addr + 8'(i);
            ref_mem[a] = wdata[8*i +: 8];
          end
        end else begin
          ref_mem[addr] = wdata[7:0];
        end
      end else begin
        if (size) ref_rdata = {ref_mem[addr+8'd3], ref_mem[addr+8'd2], ref_mem[addr+8'd1], ref_mem[addr]};
        else      ref_rdata = {24'h0, ref_mem[addr]};
      end
    end
    exp_q.push_back({mis, ref_rdata});
    exp_lat = mis ? 1 : (size ? 5 : 2);

    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw = rw;
    mem_size = size;
    mem_addr = addr;
    mem_wdata = wdata;
    #1 check("busy_req_cycle", {31'h0, mem_busy}, 32'h1);
    cycles = 0;
    got_done = 1'b0;
    while (!got_done && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
      if (mem_done) begin
        got_done = 1'b1;
        mem_enable = 1'b0;
      end else begin
        check("busy_in_xfer", {31'h0, mem_busy}, 32'h1);
        if (scramble) begin
          mem_enable = 1'($urandom);
          mem_rw = 1'($urandom);
          mem_size = 1'($urandom);
          mem_addr = 8'($urandom);
          mem_wdata = $urandom;
        end else begin
          mem_enable = 1'b0;
        end
      end
    end
    check("done_seen", {31'h0, got_done}, 32'h1);
    check("latency", cycles, exp_lat);
    check("busy_at_done", {31'h0, mem_busy}, 32'h0);
    @(posedge clk);
  endtask

  initial begin
    // Reset values while R is low, before any clock edge.
    #2;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_busy", {31'h0, mem_busy}, 32'h0);
    check("rst_done", {31'h0, mem_done}, 32'h0);
    check("rst_err", {31'h0, mem_err}, 32'h0);
    #20;
    @(negedge clk);
    R = 1'b1;

    // Fill all storage so every later load has a known expectation.
    for (int w = 0; w < 64; w++) do_req(1'b1, 1'b1, 8'(w * 4), $urandom, 1'b0);

    // Directed checks for word and byte access and byte order.
    do_req(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
    check("dir_word_load", ref_rdata, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 8'h11, 32'h0, 1'b0);
    check("dir_byte_load", ref_rdata, 32'h000000BE);
    do_req(1'b1, 1'b0, 8'h13, 32'h0000005A, 1'b0);
    do_req(1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
    check("dir_word_after_byte", ref_rdata, 32'h5AADBEEF);

    // A misaligned word access errors out, leaves storage alone and holds rdata.
    do_req(1'b0, 1'b1, 8'h22, 32'h0, 1'b0);
    do_req(1'b1, 1'b1, 8'h21, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 1'b1, 8'h20, 32'h0, 1'b0);

    // Top byte of the address space, then scrambled inputs during the transfer.
    do_req(1'b1, 1'b0, 8'hFF, 32'h000000FF, 1'b0);
    do_req(1'b0, 1'b0, 8'hFF, 32'h0, 1'b0);
    check("dir_byte_ff", ref_rdata, 32'h000000FF);
    do_req(1'b1, 1'b1, 8'hFC, 32'h01020304, 1'b1);
    do_req(1'b0, 1'b1, 8'hFC, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 8'h31, 32'hFFFFFFA7, 1'b1);
    do_req(1'b0, 1'b0, 8'h31, 32'h0, 1'b1);

    // Random traffic, including misaligned words.
    for (int n = 0; n < 200; n++)
      do_req(1'($urandom), 1'($urandom), 8'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));

    // Reset while idle clears rdata asynchronously.
    @(negedge clk);
    #2 R = 1'b0;
    #1;
    check("rst_idle_rdata", mem_rdata, 32'h0);
    check("rst_idle_busy", {31'h0, mem_busy}, 32'h0);
    check("rst_idle_done", {31'h0, mem_done}, 32'h0);
    check("rst_idle_err", {31'h0, mem_err}, 32'h0);
    ref_rdata = 32'h0;
    @(negedge clk);
    R = 1'b1;

    // Reset during beat 2 of a word store: only bytes 0 and 1 are written.
    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw = 1'b1;
    mem_size = 1'b1;
    mem_addr = 8'h40;
    mem_wdata = 32'h11223344;
    @(posedge clk);
    #1 mem_enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 R = 1'b0;
    #1;
    check("rst_xfer_busy", {31'h0, mem_busy}, 32'h0);
    check("rst_xfer_done", {31'h0, mem_done}, 32'h0);
    ref_mem[8'h40] = 8'h44;
    ref_mem[8'h41] = 8'h33;
    @(negedge clk);
    R = 1'b1;
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b0, 8'(8'h40 + i), 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 8'h40, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit in case the DUT stalls in a way the per-request bounds miss.
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the MEM stage of the pipelined CPU.
- Serves load/store requests driven by the EX_MEM register outputs (enable, read/write, size, address, store data).
- Storage is a byte-wide array; word accesses are serialized into four byte beats by an FSM.
- mem_busy is returned to hazard/stall logic so the pipeline register load enables (LE) can freeze while a transfer is in flight.

Parameters:
- ADDR_W, 8, address width in bits; matches the 8-bit PC/address path.
- DEPTH, 256, number of bytes of storage; must equal 2**ADDR_W.

Ports:
- clk, input, 1, rising-edge clock.
- R, input, 1, asynchronous active-low reset.
- mem_enable, input, 1, request valid from MEM stage (Enable_signal).
- mem_rw, input, 1, 1 = store, 0 = load (RW_enable).
- mem_size, input, 1, 1 = word (32 bit), 0 = byte (Size_enable).
- mem_addr, input, ADDR_W, byte address.
- mem_wdata, input, 32, store data.
- mem_rdata, output, 32, load result.
- mem_busy, output, 1, stall request to pipeline.
- mem_done, output, 1, one-cycle completion pulse.
- mem_err, output, 1, one-cycle misaligned-word pulse.

Behaviour:
- Reset: R low asynchronously forces state IDLE and sets mem_rdata = 0, mem_busy = 0, mem_done = 0, mem_err = 0, beat counter = 0.
  - Storage array is not cleared by reset.
  - Reset during XFER abandons the transfer; bytes already written stay written.
- States: IDLE, XFER, DONE, ERR.
- IDLE, mem_enable = 0: remain in IDLE.
- IDLE, mem_enable = 1 at a rising edge:
  - Capture addr, wdata, rw and size.
  - Go to ERR if size = 1 and addr[1:0] != 0; otherwise go to XFER with beat = 0.
- XFER: one byte per cycle at address (captured addr + beat).
  - Store: writes wdata byte[beat], little-endian (beat 0 = bits 7:0 at addr).
  - Load: fills rdata byte[beat].
  - Last beat is 0 for a byte access and 3 for a word access; on the last beat go to DONE, otherwise beat increments.
- DONE: mem_done = 1 for exactly one cycle, then go to IDLE.
  - The request is not re-sampled in DONE; the pipeline advances on the edge that ends DONE.
- ERR: mem_err = 1 and mem_done = 1 for one cycle, then go to IDLE.
  - No storage change; mem_rdata is unchanged.
- mem_busy (combinational) = (state == XFER) OR (state == IDLE AND mem_enable); it is 0 in DONE and ERR.
  - This stalls in the request cycle itself, with no bubble.
- Latency from the accepting IDLE cycle (cycle 0):
  - Byte: XFER in cycle 1, DONE in cycle 2; mem_busy high in cycles 0-1.
  - Word: XFER in cycles 1-4, DONE in cycle 5; mem_busy high in cycles 0-4.
- Load result:
  - Byte loads zero-extend: rdata[31:8] = 0.
  - mem_rdata is updated only by loads and holds its value through stores, errors and idle cycles until the next load completes.
  - For a word load, mem_rdata is valid when mem_done = 1; intermediate cycles may show partial bytes.
- Store writes touch only the addressed bytes.
- Address arithmetic is ADDR_W bits wide.
  - Aligned words never wrap; byte 255 is valid.
  - Any address within the array is legal; there is no out-of-range error.
- Changes to mem_enable or other inputs during XFER, DONE or ERR are ignored; captured values are used.
- Back-to-back requests: after DONE the FSM is in IDLE and accepts a request one cycle later. The minimum period is 3 cycles for byte accesses and 6 cycles for word accesses.

Test Plan:
- Reset: R = 0 mid-idle, then R = 1 -> rdata = 0, busy = 0, done = 0, err = 0 while R is low, with no clock needed.
- Word store then load: store 0xDEADBEEF at 0x10 (busy high 5 cycles, done at cycle 5), then word load 0x10 -> rdata = 0xDEADBEEF at done.
- Byte access and endianness: after the above, byte load 0x11 -> rdata = 0x000000BE at cycle 2. Byte store 0x5A to 0x13, then word load 0x10 -> 0x5AADBEEF.
- Misaligned word: word load at 0x22 -> err = 1 and done = 1 in cycle 1, busy = 1 only in cycle 0, memory unchanged, rdata holds its previous value.
- Reset mid-operation: word store 0x11223344 at 0x40, assert R low during beat 2 -> state IDLE, busy = 0. Bytes 0x40 = 0x44 and 0x41 = 0x33; 0x42 and 0x43 keep their old values, verified by a later byte load.
- Boundary and ignore: byte store 0xFF to 0xFF then load -> 0x000000FF. Toggle mem_addr/mem_wdata during XFER -> result uses the captured values.
